fwd_ctrl: RTL and testbench
===========================

# fwd_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks destination-register information for the instructions in EX, MEM and WB in its own shift register. It produces registered 2-bit select codes that drive the `mux_3` operand selectors in EX, and a combinational stall request for load-use hazards. It sits beside the ID/EX pipeline register and advances in lockstep with it.

## Interface
- `RA_W`, 5, register-address width.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hold`  in  1  global freeze (memory wait); nothing advances.
- `flush`  in  1  branch/jump taken in EX; the ID instruction is killed.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  RA_W  source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  the source is actually read.
- `id_rd`  in  RA_W  destination of the ID instruction.
- `id_reg_write`  in  1  the ID instruction writes `id_rd`.
- `id_mem_read`  in  1  the ID instruction is a load.
- `fwd_a`, `fwd_b`  out  2  operand-A/B select for the EX `mux_3`: 00 regfile, 01 WB result, 1x MEM (ALU) result.
- `stall`  out  1  load-use stall: hold PC and IF/ID, insert a bubble into ID/EX.

## Operation
- Three slots: EX, MEM and WB. Each slot holds {valid, rd, reg_write, mem_read}.
- A slot is a producer only if valid && reg_write && rd != 0.
- Advance (`adv` = !hold): WB ← MEM, MEM ← EX, EX ← incoming entry.
- Incoming entry:
  - Bubble (valid=0) when `flush` or `stall` is set.
  - Otherwise the ID fields, with valid = `id_valid`.
- Forward selects are computed at advance time for the entering instruction and registered into `fwd_a`/`fwd_b`:
  - Current EX-slot producer with rd == rs, and use set → 10. It will be in MEM during consumer EX.
  - Else current MEM-slot producer match → 01. It will be in WB during consumer EX.
  - Else 00.
  - EX-slot match has priority over MEM-slot match.
- If the entering entry is a bubble, the selects register as 00.
- `stall` = !flush && id_valid && EX-slot producer with mem_read && (rs1 match && use_rs1 || rs2 match && use_rs2).
  - The match is against the current EX slot only.
  - After one bubble the load sits in MEM. The consumer then enters and gets 01 (WB forward of load data).
- Flush and a load-use hazard in the same cycle: flush wins, `stall` = 0, bubble inserted.
- `hold` and `flush`/`stall` together: nothing advances. `stall` is still reported combinationally.
- Producers 3 ahead are not forwarded. The register file must be write-first (same-cycle write visible to the ID read). This is a required property of the regfile.
- Register 0 is never forwarded and never stalls.

## Timing
- Reset (async, immediate): all slot valids 0, `fwd_a` = `fwd_b` = 00. `stall` is therefore 0 combinationally.
- `fwd_*` latency: registered at the edge where the consumer enters EX, and valid for its entire EX cycle.
- `stall` is purely combinational from the EX slot and the ID inputs, with no added latency. It lasts exactly 1 cycle per load-use pair (unless `hold`).
- Reset released mid-sequence: the pipeline restarts with an empty scoreboard. No stale forwards.

## Structure
- Shared package `cpu_pkg`:
  - localparams `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10.
  - Slot struct/typedef `hz_slot_t` {valid, rd, reg_write, mem_read}.
  - `RA_W`.
- One natural sub-module, `fwd_sel`: a combinational per-operand select generator (rs, use, EX slot, MEM slot → 2-bit code). It is instantiated twice.
- Slots and output registers live in `fwd_ctrl`.

## Test plan
- `add x5` then `sub x6,x5,x1` back-to-back → `fwd_a` = 10 during sub's EX; `fwd_b` = 00.
- `add x5`, `nop`, `or x7,x2,x5` → `fwd_b` = 01 in or's EX cycle.
- `add x5`, `addi x5`, `and x8,x5,x5` → `fwd_a` = `fwd_b` = 10 (newest wins).
- `lw x7`, `add x9,x7,x3` → `stall` = 1 for exactly one cycle, bubble in EX, then `fwd_a` = 01. With `flush` = 1 in the stall cycle → `stall` = 0.
- Producer writes x0, consumer reads x0 → `fwd` = 00, `stall` = 0. A load to x0 followed by a use → no stall.
- `hold` = 1 for 3 cycles mid-sequence → slots and `fwd_*` frozen. Assert `rst_n` = 0 during a stall → `stall` and `fwd_*` go to 0 immediately, before any clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline types: register-address width, forward select codes and the
// hazard-tracking slot record used by the forwarding controller.
package cpu_pkg;

   localparam int RA_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
   } hz_slot_t;

   // x0 is hard-wired, so an instruction targeting it never produces a value.
   function automatic logic is_producer(input hz_slot_t s);
      return s.valid && s.reg_write && (s.rd != '0);
   endfunction

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-side request and EX-side select bundle between the pipeline and fwd_ctrl;
// the three scoreboard slots are exported read-only for observation.
interface fwd_ctrl_if;
   import cpu_pkg::*;

   logic            hold;
   logic            flush;
   logic            id_valid;
   logic [RA_W-1:0] id_rs1;
   logic [RA_W-1:0] id_rs2;
   logic            id_use_rs1;
   logic            id_use_rs2;
   logic [RA_W-1:0] id_rd;
   logic            id_reg_write;
   logic            id_mem_read;

   logic [1:0]      fwd_a;
   logic [1:0]      fwd_b;
   logic            stall;
   hz_slot_t        ex_slot;
   hz_slot_t        mem_slot;
   hz_slot_t        wb_slot;

   modport master (
      output hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read,
      input  fwd_a, fwd_b, stall, ex_slot, mem_slot, wb_slot
   );

   modport slave (
      input  hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read,
      output fwd_a, fwd_b, stall, ex_slot, mem_slot, wb_slot
   );

endinterface

// File: rtl/fwd_sel.sv
// Per-operand forward select: the youngest matching producer ahead of the
// consumer wins; producers three ahead are served by the write-first regfile.
module fwd_sel
   import cpu_pkg::*;
(
   input  logic [RA_W-1:0] rs_i,
   input  logic            use_i,
   input  logic            ex_prod_i,
   input  logic [RA_W-1:0] ex_rd_i,
   input  logic            mem_prod_i,
   input  logic [RA_W-1:0] mem_rd_i,
   output logic [1:0]      sel_o
);

   always_comb begin
      // NOTE: default assigned first so every path drives sel_o and no latch is inferred.
      sel_o = FWD_RF;
      if (use_i && ex_prod_i && (ex_rd_i == rs_i)) begin
         sel_o = FWD_MEM;
      end else if (use_i && mem_prod_i && (mem_rd_i == rs_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding / load-use hazard controller: EX/MEM/WB destination scoreboard
// advancing in lockstep with ID/EX, registered mux_3 selects, combinational stall.
module fwd_ctrl
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   fwd_ctrl_if.slave  bus
);

   hz_slot_t   ex_q, mem_q, wb_q;
   hz_slot_t   ex_d;
   logic [1:0] fwd_a_q, fwd_b_q;
   logic [1:0] fwd_a_d, fwd_b_d;
   logic [1:0] sel_a, sel_b;
   logic       adv, ex_prod, mem_prod, load_use, bubble;

   assign adv      = !bus.hold;
   assign ex_prod  = is_producer(ex_q);
   assign mem_prod = is_producer(mem_q);

   // Only a load sitting in EX is too late to forward; one bubble moves it to MEM.
   assign load_use = ex_prod && ex_q.mem_read &&
                     ((bus.id_use_rs1 && (ex_q.rd == bus.id_rs1)) ||
                      (bus.id_use_rs2 && (ex_q.rd == bus.id_rs2)));

   assign bus.stall = !bus.flush && bus.id_valid && load_use;
   assign bubble    = bus.flush || bus.stall;

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid     = bus.id_valid;
         ex_d.rd        = bus.id_rd;
         ex_d.reg_write = bus.id_reg_write;
         ex_d.mem_read  = bus.id_mem_read;
      end
   end

   fwd_sel u_sel_a (
      .rs_i       (bus.id_rs1),
      .use_i      (bus.id_use_rs1),
      .ex_prod_i  (ex_prod),
      .ex_rd_i    (ex_q.rd),
      .mem_prod_i (mem_prod),
      .mem_rd_i   (mem_q.rd),
      .sel_o      (sel_a)
   );

   fwd_sel u_sel_b (
      .rs_i       (bus.id_rs2),
      .use_i      (bus.id_use_rs2),
      .ex_prod_i  (ex_prod),
      .ex_rd_i    (ex_q.rd),
      .mem_prod_i (mem_prod),
      .mem_rd_i   (mem_q.rd),
      .sel_o      (sel_b)
   );

   assign fwd_a_d = ex_d.valid ? sel_a : FWD_RF;
   assign fwd_b_d = ex_d.valid ? sel_b : FWD_RF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else if (adv) begin
         // NOTE: non-blocking so each slot shifts from its pre-edge neighbour.
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign bus.fwd_a    = fwd_a_q;
   assign bus.fwd_b    = fwd_b_q;
   assign bus.ex_slot  = ex_q;
   assign bus.mem_slot = mem_q;
   assign bus.wb_slot  = wb_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: an age-ordered pipeline model checked every
// negedge, plus literal expectations at the interesting points of each sequence.
module tb_fwd_ctrl;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic started = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   fwd_ctrl_if bus ();

   fwd_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } instr_t;

   function automatic instr_t op_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return '{v:1'b1, rs1:rs1, u1:1'b1, rs2:rs2, u2:1'b1, rd:rd, rw:1'b1, mr:1'b0};
   endfunction

   function automatic instr_t op_i(input logic [4:0] rd, input logic [4:0] rs1);
      return '{v:1'b1, rs1:rs1, u1:1'b1, rs2:5'd0, u2:1'b0, rd:rd, rw:1'b1, mr:1'b0};
   endfunction

   function automatic instr_t op_lw(input logic [4:0] rd, input logic [4:0] rs1);
      return '{v:1'b1, rs1:rs1, u1:1'b1, rs2:5'd0, u2:1'b0, rd:rd, rw:1'b1, mr:1'b1};
   endfunction

   function automatic instr_t op_nop();
      return '0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic put(input instr_t i);
      bus.id_valid     = i.v;
      bus.id_rs1       = i.rs1;
      bus.id_use_rs1   = i.u1;
      bus.id_rs2       = i.rs2;
      bus.id_use_rs2   = i.u2;
      bus.id_rd        = i.rd;
      bus.id_reg_write = i.rw;
      bus.id_mem_read  = i.mr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      put(op_nop());
      cyc();
      cyc();
      cyc();
   endtask

   // Model: m_age[0] is the instruction one ahead of ID (EX), [1] two ahead, [2] three ahead.
   hz_slot_t   m_age [3];
   logic [1:0] m_fa, m_fb;

   function automatic logic m_prod(input hz_slot_t s);
      return s.valid && s.reg_write && (s.rd != 5'd0);
   endfunction

   function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic use_it);
      for (int d = 0; d < 2; d++) begin
         if (use_it && m_prod(m_age[d]) && (m_age[d].rd == rs))
            return (d == 0) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic logic m_stall();
      if (bus.flush || !bus.id_valid) return 1'b0;
      if (!(m_prod(m_age[0]) && m_age[0].mem_read)) return 1'b0;
      return (bus.id_use_rs1 && (bus.id_rs1 == m_age[0].rd)) ||
             (bus.id_use_rs2 && (bus.id_rs2 == m_age[0].rd));
   endfunction

   function automatic hz_slot_t m_enter();
      if (bus.flush || m_stall()) return '0;
      return '{valid:bus.id_valid, rd:bus.id_rd, reg_write:bus.id_reg_write, mem_read:bus.id_mem_read};
   endfunction

   function automatic logic [1:0] m_next_sel(input logic [4:0] rs, input logic use_it);
      hz_slot_t e;
      e = m_enter();
      if (!e.valid) return 2'b00;
      return m_sel(rs, use_it);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) m_age[k] <= '0;
         m_fa <= 2'b00;
         m_fb <= 2'b00;
      end else if (!bus.hold) begin
         m_age[0] <= m_enter();
         m_age[1] <= m_age[0];
         m_age[2] <= m_age[1];
         m_fa     <= m_next_sel(bus.id_rs1, bus.id_use_rs1);
         m_fb     <= m_next_sel(bus.id_rs2, bus.id_use_rs2);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("model_fwd_a",    32'(bus.fwd_a),    32'(m_fa));
         check("model_fwd_b",    32'(bus.fwd_b),    32'(m_fb));
         check("model_stall",    32'(bus.stall),    32'(m_stall()));
         check("model_ex_slot",  32'(bus.ex_slot),  32'(m_age[0]));
         check("model_mem_slot", 32'(bus.mem_slot), 32'(m_age[1]));
         check("model_wb_slot",  32'(bus.wb_slot),  32'(m_age[2]));
      end
   end

   initial begin
      put(op_nop());
      bus.hold  = 1'b0;
      bus.flush = 1'b0;
      #2 rst_n = 1'b0;
      started = 1'b1;
      #1;
      check("reset_fwd_a", 32'(bus.fwd_a), 32'h0);
      check("reset_fwd_b", 32'(bus.fwd_b), 32'h0);
      check("reset_stall", 32'(bus.stall), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // add x5 ; sub x6,x5,x1
      put(op_r(5, 1, 2)); cyc();
      put(op_r(6, 5, 1)); cyc();
      check("t1_fwd_a", 32'(bus.fwd_a), 32'h2);
      check("t1_fwd_b", 32'(bus.fwd_b), 32'h0);
      drain();

      // add x5 ; nop ; or x7,x2,x5
      put(op_r(5, 1, 2)); cyc();
      put(op_nop());      cyc();
      put(op_r(7, 2, 5)); cyc();
      check("t2_fwd_a", 32'(bus.fwd_a), 32'h0);
      check("t2_fwd_b", 32'(bus.fwd_b), 32'h1);
      drain();

      // add x5 ; addi x5,x5 ; and x8,x5,x5
      put(op_r(5, 1, 2)); cyc();
      put(op_i(5, 5));    cyc();
      check("t3_addi_fwd_a", 32'(bus.fwd_a), 32'h2);
      put(op_r(8, 5, 5)); cyc();
      check("t3_fwd_a", 32'(bus.fwd_a), 32'h2);
      check("t3_fwd_b", 32'(bus.fwd_b), 32'h2);
      drain();

      // lw x7 ; add x9,x7,x3 : one stall, bubble, then WB forward
      put(op_lw(7, 1));   cyc();
      put(op_r(9, 7, 3)); #1;
      check("t4_stall_on", 32'(bus.stall), 32'h1);
      cyc();
      check("t4_stall_off", 32'(bus.stall), 32'h0);
      check("t4_bubble", 32'(bus.ex_slot.valid), 32'h0);
      cyc();
      check("t4_fwd_a", 32'(bus.fwd_a), 32'h1);
      check("t4_fwd_b", 32'(bus.fwd_b), 32'h0);
      drain();

      // same pair with flush in the hazard cycle
      put(op_lw(7, 1));   cyc();
      put(op_r(9, 7, 3)); bus.flush = 1'b1; #1;
      check("t5_stall_flush", 32'(bus.stall), 32'h0);
      cyc();
      check("t5_bubble", 32'(bus.ex_slot.valid), 32'h0);
      check("t5_fwd_a", 32'(bus.fwd_a), 32'h0);
      bus.flush = 1'b0;
      drain();

      // x0 is never forwarded and never stalls
      put(op_r(0, 1, 2)); cyc();
      put(op_r(1, 0, 0)); #1;
      check("t6_x0_stall", 32'(bus.stall), 32'h0);
      cyc();
      check("t6_x0_fwd_a", 32'(bus.fwd_a), 32'h0);
      check("t6_x0_fwd_b", 32'(bus.fwd_b), 32'h0);
      put(op_lw(0, 1));   cyc();
      put(op_r(2, 0, 0)); #1;
      check("t6_lw_x0_stall", 32'(bus.stall), 32'h0);
      cyc();
      check("t6_lw_x0_fwd_a", 32'(bus.fwd_a), 32'h0);
      drain();

      // hold for 3 cycles with a live forward
      put(op_r(5, 1, 2));  cyc();
      put(op_r(6, 5, 1));  cyc();
      put(op_r(10, 6, 5)); bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("t7_hold_fwd_a", 32'(bus.fwd_a), 32'h2);
         check("t7_hold_ex_rd", 32'(bus.ex_slot.rd), 32'd6);
      end
      bus.hold = 1'b0;
      cyc();
      check("t7_after_fwd_a", 32'(bus.fwd_a), 32'h2);
      check("t7_after_fwd_b", 32'(bus.fwd_b), 32'h1);
      drain();

      // hold during a load-use stall
      put(op_lw(7, 1));   cyc();
      put(op_r(9, 7, 3)); bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("t7_hold_stall", 32'(bus.stall), 32'h1);
         check("t7_hold_lw_rd", 32'(bus.ex_slot.rd), 32'd7);
      end
      bus.hold = 1'b0;
      cyc();
      check("t7_release_stall", 32'(bus.stall), 32'h0);
      cyc();
      check("t7_release_fwd_a", 32'(bus.fwd_a), 32'h1);
      drain();

      // async reset in the middle of a stall
      put(op_r(7, 1, 2)); cyc();
      put(op_lw(7, 7));   cyc();
      put(op_r(9, 7, 3)); #1;
      check("t8_pre_stall", 32'(bus.stall), 32'h1);
      check("t8_pre_fwd_a", 32'(bus.fwd_a), 32'h2);
      #1 rst_n = 1'b0;
      #1;
      check("t8_rst_stall", 32'(bus.stall), 32'h0);
      check("t8_rst_fwd_a", 32'(bus.fwd_a), 32'h0);
      check("t8_rst_fwd_b", 32'(bus.fwd_b), 32'h0);
      check("t8_rst_ex_valid", 32'(bus.ex_slot.valid), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc();
      check("t8_restart_fwd_a", 32'(bus.fwd_a), 32'h0);
      check("t8_restart_stall", 32'(bus.stall), 32'h0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
